// File: rtl/axi_fifo_pkg.sv
// axi_fifo_pkg: AXI field widths and the fixed-width AW attribute bundle shared by the write-channel FIFO
package axi_fifo_pkg;
  localparam int LEN_W    = 8;
  localparam int SIZE_W   = 3;
  localparam int BURST_W  = 2;
  localparam int LOCK_W   = 1;
  localparam int CACHE_W  = 4;
  localparam int PROT_W   = 3;
  localparam int QOS_W    = 4;
  localparam int REGION_W = 4;
  localparam int RESP_W   = 2;
  // AW attributes whose widths do not depend on any module parameter
  typedef struct packed {
    logic [LEN_W-1:0]    len;
    logic [SIZE_W-1:0]   size;
    logic [BURST_W-1:0]  burst;
    logic [LOCK_W-1:0]   lock;
    logic [CACHE_W-1:0]  cache;
    logic [PROT_W-1:0]   prot;
    logic [QOS_W-1:0]    qos;
    logic [REGION_W-1:0] region;
  } aw_attr_t;
endpackage

// File: rtl/axi_sync_fifo.sv
// axi_sync_fifo: single-clock first-word-fall-through FIFO, DEPTH a power of two >= 2
// Ports: clk, rst_n (async active-low); push_i/data_i write side; pop_i/data_o read side
//        (data_o is the head entry whenever empty_o is low); full_o, empty_o status.
// A push while full is accepted only when a pop happens in the same cycle.
module axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  assign data_o  = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/axi_wr_fifo.sv
// axi_wr_fifo: AXI4 write-channel buffer -- FWFT FIFOs on AW and W, 2-entry skid buffer on B
// Ports: clk, rst_n (async active-low); s_axi_aw*/s_axi_w*/s_axi_b* slave side;
//        m_axi_aw*/m_axi_w*/m_axi_b* master side (same fields, directions reversed).
// Optional macro AXI_WR_FIFO_AW_HOLD_EN: hold m_axi_awvalid until a complete burst
// (a W beat with wlast) is buffered; needs W_FIFO_DEPTH >= 256.
module axi_wr_fifo
  import axi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int STRB_WIDTH    = DATA_WIDTH/8,
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_WIDTH      = 8,
  parameter int AWUSER_WIDTH  = 1,
  parameter int WUSER_WIDTH   = 1,
  parameter int BUSER_WIDTH   = 1,
  parameter int AW_FIFO_DEPTH = 16,
  parameter int W_FIFO_DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [LEN_W-1:0]        s_axi_awlen,
  input  logic [SIZE_W-1:0]       s_axi_awsize,
  input  logic [BURST_W-1:0]      s_axi_awburst,
  input  logic [LOCK_W-1:0]       s_axi_awlock,
  input  logic [CACHE_W-1:0]      s_axi_awcache,
  input  logic [PROT_W-1:0]       s_axi_awprot,
  input  logic [QOS_W-1:0]        s_axi_awqos,
  input  logic [REGION_W-1:0]     s_axi_awregion,
  input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [WUSER_WIDTH-1:0]  s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [RESP_W-1:0]       s_axi_bresp,
  output logic [BUSER_WIDTH-1:0]  s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [LEN_W-1:0]        m_axi_awlen,
  output logic [SIZE_W-1:0]       m_axi_awsize,
  output logic [BURST_W-1:0]      m_axi_awburst,
  output logic [LOCK_W-1:0]       m_axi_awlock,
  output logic [CACHE_W-1:0]      m_axi_awcache,
  output logic [PROT_W-1:0]       m_axi_awprot,
  output logic [QOS_W-1:0]        m_axi_awqos,
  output logic [REGION_W-1:0]     m_axi_awregion,
  output logic [AWUSER_WIDTH-1:0] m_axi_awuser,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic [WUSER_WIDTH-1:0]  m_axi_wuser,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [RESP_W-1:0]       m_axi_bresp,
  input  logic [BUSER_WIDTH-1:0]  m_axi_buser,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);
  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic [ADDR_WIDTH-1:0]   addr;
    aw_attr_t                attr;
    logic [AWUSER_WIDTH-1:0] user;
  } aw_entry_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [STRB_WIDTH-1:0]  strb;
    logic                   last;
    logic [WUSER_WIDTH-1:0] user;
  } w_entry_t;
  typedef struct packed {
    logic [ID_WIDTH-1:0]    id;
    logic [RESP_W-1:0]      resp;
    logic [BUSER_WIDTH-1:0] user;
  } b_entry_t;
  aw_entry_t aw_in, aw_out;
  w_entry_t w_in, w_out;
  b_entry_t b_in, b_out;
  logic rdy_q;
  logic aw_full, aw_empty, w_full, w_empty, b_full, b_empty;
  logic aw_push, aw_pop, w_push, w_pop, b_push, b_pop;
  // Readies stay low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdy_q <= 1'b0;
    else rdy_q <= 1'b1;
  assign aw_in = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
                  s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion, s_axi_awuser};
  assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
          m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion, m_axi_awuser} = aw_out;
  assign w_in = {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser};
  assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser} = w_out;
  assign b_in = {m_axi_bid, m_axi_bresp, m_axi_buser};
  assign {s_axi_bid, s_axi_bresp, s_axi_buser} = b_out;
  assign s_axi_awready = rdy_q && !aw_full;
  assign s_axi_wready  = rdy_q && !w_full;
  assign m_axi_bready  = rdy_q && !b_full;
  assign m_axi_wvalid  = !w_empty;
  assign s_axi_bvalid  = !b_empty;
  assign aw_push = s_axi_awvalid && s_axi_awready;
  assign aw_pop  = m_axi_awvalid && m_axi_awready;
  assign w_push  = s_axi_wvalid && s_axi_wready;
  assign w_pop   = m_axi_wvalid && m_axi_wready;
  assign b_push  = m_axi_bvalid && m_axi_bready;
  assign b_pop   = s_axi_bvalid && s_axi_bready;
`ifdef AXI_WR_FIFO_AW_HOLD_EN
  localparam int BC_W = $clog2(W_FIFO_DEPTH) + 1;
  logic [BC_W-1:0] burst_q, burst_d;
  if (W_FIFO_DEPTH < 256) begin : g_depth_chk
    $error("axi_wr_fifo: AXI_WR_FIFO_AW_HOLD_EN requires W_FIFO_DEPTH >= 256");
  end
  // Complete bursts buffered in W but not yet matched by an issued AW.
  assign burst_d = burst_q + BC_W'(w_push && s_axi_wlast) - BC_W'(aw_pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) burst_q <= '0;
    else burst_q <= burst_d;
  assign m_axi_awvalid = !aw_empty && burst_q != '0;
`else
  assign m_axi_awvalid = !aw_empty;
`endif
  axi_sync_fifo #(.WIDTH($bits(aw_entry_t)), .DEPTH(AW_FIFO_DEPTH)) u_aw_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(aw_push), .data_i(aw_in), .pop_i(aw_pop),
    .data_o(aw_out), .full_o(aw_full), .empty_o(aw_empty));
  axi_sync_fifo #(.WIDTH($bits(w_entry_t)), .DEPTH(W_FIFO_DEPTH)) u_w_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(w_push), .data_i(w_in), .pop_i(w_pop),
    .data_o(w_out), .full_o(w_full), .empty_o(w_empty));
  // Two registered entries sustain one response per cycle while keeping bready registered.
  axi_sync_fifo #(.WIDTH($bits(b_entry_t)), .DEPTH(2)) u_b_skid (
    .clk(clk), .rst_n(rst_n), .push_i(b_push), .data_i(b_in), .pop_i(b_pop),
    .data_o(b_out), .full_o(b_full), .empty_o(b_empty));
endmodule
